// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit glitch rejection, first-word fall-through RX FIFO and sticky errors.
// Define UART_RX_PARITY_EN to enable the parity bit check (parity_mode/parity_err); otherwise no parity bit is expected.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          clk_div,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rd_en,
    input  logic                 err_clr,
    input  logic                 irq_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 irq
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic                 rx_meta_reg, rx_s;
    logic [2:0]           state_reg;
    logic [31:0]          cnt_reg, div, half_m1;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop2_reg;
    logic                 bit_tick, stop_tick, push, frame_set, parity_set, par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    assign div      = (clk_div < 32'd2) ? 32'd2 : clk_div;
    assign half_m1  = (div >> 1) - 32'd1;
    assign bit_tick = (cnt_reg == div - 32'd1);

`ifdef UART_RX_PARITY_EN
    logic par_on, par_calc_bad, par_bad_reg;
    logic parity_err_reg;
    assign par_on       = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    // Even: data^parity reduces to 0; odd: reduces to 1.
    assign par_calc_bad = ((^shift_reg) ^ rx_s) != (parity_mode == 2'b10);
    assign parity_set   = (state_reg == S_PARITY) && bit_tick && par_calc_bad;
    assign par_bad      = par_bad_reg;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
    assign parity_set         = 1'b0;
    assign par_bad            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            stop2_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_reg == half_m1) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx_reg == LAST_BIT) begin
                            stop2_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_bad_reg <= 1'b0;
                            state_reg   <= par_on ? S_PARITY : S_STOP;
`else
                            state_reg <= S_STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt_reg     <= '0;
                        par_bad_reg <= par_calc_bad;
                        state_reg   <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        cnt_reg <= '0;
                        if (!rx_s)
                            state_reg <= S_BREAK;
                        else if (two_stop && !stop2_reg)
                            stop2_reg <= 1'b1;
                        else
                            state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign stop_tick = (state_reg == S_STOP) && bit_tick;
    assign frame_set = stop_tick && !rx_s;
    assign push      = stop_tick && rx_s && !(two_stop && !stop2_reg) && !par_bad;

    // FIFO: a push into a full FIFO only lands if a pop frees a slot the same cycle.
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [DATA_BITS-1:0] rd_data_reg;
    logic                 pop, wr_en, overrun_set;
    logic                 frame_err_reg, overrun_reg, irq_reg;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop         = rd_en && !empty;
    assign wr_en       = push && (!full || rd_en);
    assign overrun_set = push && full && !rd_en;
    assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign count_next  = count_reg + CNT_W'(wr_en) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Registered head read; bypass when the new head is being written this cycle.
            if (count_next == '0)
                rd_data_reg <= '0;
            else if (wr_en && (rd_ptr_next == wr_ptr_reg))
                rd_data_reg <= shift_reg;
            else
                rd_data_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            frame_err_reg <= frame_set | (frame_err_reg & ~err_clr);
            overrun_reg   <= overrun_set | (overrun_reg & ~err_clr);
            irq_reg       <= irq_en & (~empty | frame_err_reg | parity_err | overrun_reg);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err_reg <= 1'b0;
        else     parity_err_reg <= parity_set | (parity_err_reg & ~err_clr);
    end
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data   = rd_data_reg;
    assign count     = count_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign irq       = irq_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: frames are driven bit by bit at clk_div=16
// and FIFO contents, status and sticky flags are compared with hand-computed values.
module tb_uart_rx_fifo;
    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] clk_div;
    logic        rx;
    logic [1:0]  parity_mode;
    logic        two_stop, rd_en, err_clr, irq_en;
    logic [7:0]  rd_data;
    logic        empty, full;
    logic [4:0]  count;
    logic        frame_err, parity_err, overrun, irq;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .rx(rx),
        .parity_mode(parity_mode), .two_stop(two_stop), .rd_en(rd_en),
        .err_clr(err_clr), .irq_en(irq_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    // Drives n bits LSB first, one bit per BIT cycles, then one idle bit time.
    task automatic send_bits(input logic [15:0] bits, input int n);
        $display("frame 0x%04h (%0d bits)", bits, n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            tick(BIT);
        end
        rx = 1'b1;
        tick(BIT);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits({6'h3f, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(2);
    endtask

    initial begin
        clk_div = 32'd16; parity_mode = 2'b00; two_stop = 1'b0;
        rd_en = 1'b0; err_clr = 1'b0; irq_en = 1'b1;
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_irq", irq, 0);
        check("rst_flags", {frame_err, parity_err, overrun}, 0);

        // 8N1 0xA5
        send_byte(8'hA5);
        check("t1_rd_data", rd_data, 8'hA5);
        check("t1_count", count, 1);
        check("t1_flags", {frame_err, parity_err, overrun}, 0);
        check("t1_irq", irq, 1);
        pop();
        check("t1_pop_empty", empty, 1);
        pop();
        check("empty_pop_count", count, 0);
        check("empty_pop_data", rd_data, 0);

        // 4-cycle start glitch is rejected; a following frame still decodes
        rx = 1'b0; tick(4); rx = 1'b1; tick(40);
        check("t2_count", count, 0);
        check("t2_flags", {frame_err, parity_err, overrun}, 0);
        send_byte(8'h3C);
        check("t2_after_data", rd_data, 8'h3C);
        pop();

`ifdef UART_RX_PARITY_EN
        parity_mode = 2'b01;
        send_bits({5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        check("t3_parity_err", parity_err, 1);
        check("t3_bad_count", count, 0);
        pulse_clr();
        check("t3_clr", parity_err, 0);
        send_bits({5'h1f, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        check("t3_good_count", count, 1);
        check("t3_good_data", rd_data, 8'h03);
        check("t3_good_perr", parity_err, 0);
        pop();
        parity_mode = 2'b10;
        send_bits({5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        check("t3_odd_data", rd_data, 8'h03);
        check("t3_odd_perr", parity_err, 0);
        pop();
`else
        parity_mode = 2'b01;
        send_byte(8'h03);
        check("t3_nopar_count", count, 1);
        check("t3_nopar_data", rd_data, 8'h03);
        check("t3_nopar_perr", parity_err, 0);
        pop();
`endif
        parity_mode = 2'b00;

        // 8N2 with bad second stop bit
        two_stop = 1'b1;
        send_bits({5'h1f, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        check("t4_frame_err", frame_err, 1);
        check("t4_count", count, 0);
        check("t4_irq", irq, 1);
        pulse_clr();
        check("t4_clr", frame_err, 0);
        check("t4_irq_clr", irq, 0);
        send_bits({5'h1f, 1'b1, 1'b1, 8'h5A, 1'b0}, 11);
        check("t4_good_data", rd_data, 8'h5A);
        check("t4_good_ferr", frame_err, 0);
        pop();
        two_stop = 1'b0;

        // overfill: 17 bytes into 16 entries
        do_reset();
        for (int i = 0; i <= 16; i++) send_byte(8'(i));
        check("t5_full", full, 1);
        check("t5_count", count, 16);
        check("t5_overrun", overrun, 1);
        for (int i = 0; i < 16; i++) begin
            check("t5_order", rd_data, i);
            pop();
        end
        check("t5_empty", empty, 1);
        check("t5_tail_data", rd_data, 0);

        // reset in the middle of a 0xFF frame
        do_reset();
        rx = 1'b0; tick(BIT);
        rx = 1'b1; tick(3 * BIT);
        rst = 1'b1; tick(2); rst = 1'b0;
        tick(2 * BIT);
        check("t6_abandon", count, 0);
        send_byte(8'h42);
        check("t6_count", count, 1);
        check("t6_data", rd_data, 8'h42);
        check("t6_flags", {frame_err, parity_err, overrun}, 0);
        irq_en = 1'b0; tick(2);
        check("t6_irq_dis", irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
